// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types, topology constants and tap tables for lfsr_gen
package lfsr_pkg;

  typedef enum logic {
    LFSR_IDLE = 1'b0,
    LFSR_RUN  = 1'b1
  } lfsr_state_e;

  localparam int LFSR_FIB = 0;
  localparam int LFSR_GAL = 1;

  // Maximal-length feedback masks for the Fibonacci form (fb = ^(state & mask)).
  // Bit e set means x^e appears in the primitive polynomial below x^width.
  function automatic logic [31:0] lfsr_fib_taps(input int width);
    logic [31:0] mask;
    case (width)
      3:       mask = 32'h0000_0003;
      4:       mask = 32'h0000_0003;
      5:       mask = 32'h0000_0005;
      8:       mask = 32'h0000_0071;
      16:      mask = 32'h0000_6801;
      32:      mask = 32'h0040_0007;
      default: mask = 32'h0000_0000;
    endcase
    return mask;
  endfunction

  // Maximal-length XOR masks for the right-shifting Galois form; each is the
  // Fibonacci polynomial above mirrored (bit e maps to bit width-1-e).
  function automatic logic [31:0] lfsr_gal_taps(input int width);
    logic [31:0] mask;
    case (width)
      3:       mask = 32'h0000_0006;
      4:       mask = 32'h0000_000C;
      5:       mask = 32'h0000_0014;
      8:       mask = 32'h0000_008E;
      16:      mask = 32'h0000_8016;
      32:      mask = 32'hE000_0200;
      default: mask = 32'h0000_0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// rtl/lfsr_next.sv - combinational one-step next-state function for lfsr_gen
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int                  NUM_BITS = 5,
  parameter logic [NUM_BITS-1:0] TAPS     = NUM_BITS'(5'b00101),
  parameter int                  GALOIS   = LFSR_FIB
) (
  input  logic [NUM_BITS-1:0] i_state,
  output logic [NUM_BITS-1:0] o_next
);

  generate
    if (GALOIS != LFSR_FIB) begin : g_galois
      logic [NUM_BITS-1:0] w_mask;
      // Galois: shift right and fold the mask in when a one falls off the end.
      always_comb begin
        w_mask = i_state[0] ? TAPS : '0;
        o_next = (i_state >> 1) ^ w_mask;
      end
    end else begin : g_fibonacci
      logic w_fb;
      // Fibonacci: parity of the tapped bits enters at the MSB.
      always_comb begin
        w_fb   = ^(i_state & TAPS);
        o_next = {w_fb, i_state[NUM_BITS-1:1]};
      end
    end
  endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - LFSR sequence generator with seed load, wrap pulse and step counter
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int                  NUM_BITS     = 5,
  parameter logic [NUM_BITS-1:0] TAPS         = NUM_BITS'(5'b00101),
  parameter int                  GALOIS       = LFSR_FIB,
  parameter logic [NUM_BITS-1:0] SEED_DEFAULT = NUM_BITS'(1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [NUM_BITS-1:0] seed,
  output logic [NUM_BITS-1:0] lfsr_out,
  output logic                out_valid,
  output logic                wrap,
  output logic                seed_err,
  output logic [NUM_BITS-1:0] step_count
);

  localparam logic [NUM_BITS-1:0] ONE = NUM_BITS'(1);

  lfsr_state_e         r_state;
  lfsr_state_e         w_state_next;
  logic [NUM_BITS-1:0] r_lfsr;
  logic [NUM_BITS-1:0] r_ref_seed;
  logic [NUM_BITS-1:0] r_step_count;
  logic                r_wrap;
  logic                r_seed_err;
  logic [NUM_BITS-1:0] w_step_next;
  logic                w_seed_zero;
  logic [NUM_BITS-1:0] w_eff_seed;

  lfsr_next #(
    .NUM_BITS (NUM_BITS),
    .TAPS     (TAPS),
    .GALOIS   (GALOIS)
  ) u_next (
    .i_state (r_lfsr),
    .o_next  (w_step_next)
  );

  assign w_seed_zero = (seed == '0);
  assign w_eff_seed  = w_seed_zero ? SEED_DEFAULT : seed;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LFSR_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: leave IDLE on the first step or load, then stay in RUN.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LFSR_IDLE: if (en || load) w_state_next = LFSR_RUN;
      LFSR_RUN:  w_state_next = LFSR_RUN;
      default:   w_state_next = LFSR_IDLE;
    endcase
  end

  // Datapath: load has priority over step; pulses default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr       <= SEED_DEFAULT;
      r_ref_seed   <= SEED_DEFAULT;
      r_step_count <= '0;
      r_wrap       <= 1'b0;
      r_seed_err   <= 1'b0;
    end else begin
      r_wrap     <= 1'b0;
      r_seed_err <= 1'b0;
      if (load) begin
        r_lfsr       <= w_eff_seed;
        r_ref_seed   <= w_eff_seed;
        r_step_count <= '0;
        r_seed_err   <= w_seed_zero;
      end else if (en) begin
        r_lfsr <= w_step_next;
        if (w_step_next == r_ref_seed) begin
          r_wrap       <= 1'b1;
          r_step_count <= '0;
        end else begin
          r_step_count <= r_step_count + ONE;
        end
      end
    end
  end

  assign lfsr_out   = r_lfsr;
  assign out_valid  = (r_state == LFSR_RUN);
  assign wrap       = r_wrap;
  assign seed_err   = r_seed_err;
  assign step_count = r_step_count;

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised pseudo-random sequence generator: the next-generation LFSR for the DSP test-stimulus and dither paths. It supports configurable width, tap mask and Fibonacci or Galois topology, plus run-time seed load, step enable and zero-seed protection. It also produces a period-wrap pulse and a step counter, so downstream blocks can frame PRBS sequences. It sits between the control register block, which supplies seed, load and enable, and the stimulus and noise consumers that take `lfsr_out`.

## Interface
- `NUM_BITS`, 5: register width; legal range 3..32.
- `TAPS`, 5'b00101 (width `NUM_BITS`): Fibonacci mode uses it as the feedback-tap mask; Galois mode uses it as the XOR mask.
- `GALOIS`, 0: 0 = Fibonacci topology, 1 = Galois topology.
- `SEED_DEFAULT`, 1: reset seed and zero-seed substitute; must be nonzero.
- `clk`  in  1: single clock.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: advance the sequence one step this cycle.
- `load`  in  1: load `seed` this cycle.
- `seed`  in  `NUM_BITS`: seed value, sampled when `load`=1.
- `lfsr_out`  out  `NUM_BITS`: current register state.
- `out_valid`  out  1: high once the generator has left IDLE.
- `wrap`  out  1: one-cycle pulse; the register has just returned to the reference seed.
- `seed_err`  out  1: one-cycle pulse; a zero seed was loaded and `SEED_DEFAULT` was substituted.
- `step_count`  out  `NUM_BITS`: steps taken since the last load or wrap.

## Operation
- Fibonacci step: fb = XOR-reduce(state & `TAPS`); next = {fb, state[NUM_BITS-1:1]}.
  - Defaults give fb = s[0]^s[2], a maximal 31-state sequence.
- Galois step: next = (state >> 1) ^ (state[0] ? `TAPS` : 0).
- Reference seed register (`ref_seed`): holds the last effective loaded seed; it is `SEED_DEFAULT` after reset.
- FSM, two states:
  - IDLE: entered on reset.
  - RUN: entered from IDLE on the first cycle with `en` or `load`.
  - RUN has no exit except reset.
- `load`=1:
  - the register and `ref_seed` take `seed`, or `SEED_DEFAULT` if `seed`==0, in which case `seed_err` pulses;
  - `step_count` becomes 0;
  - `wrap` stays 0.
- `en`=1 with `load`=0:
  - the register takes the next state.
  - If the next state equals `ref_seed`: `wrap` pulses and `step_count` becomes 0.
  - Otherwise `step_count` increments, wrapping modulo 2^NUM_BITS.
- `load` and `en` in the same cycle: `load` wins and no step occurs.
- `en`=0 and `load`=0: all state holds; pulses are 0.
- The all-zero state is unreachable, because loads substitute zero and XOR steps from a nonzero state never produce zero.

## Timing
- Reset values:
  - `lfsr_out` = `SEED_DEFAULT`
  - `out_valid` = 0, `wrap` = 0, `seed_err` = 0
  - `step_count` = 0
  - FSM = IDLE
- Latency: all outputs are registered. The effect of `en`/`load` in cycle N is visible after the clock edge ending cycle N.
- `out_valid` rises on the same edge that performs the first step or load.
- `wrap` and `seed_err` are high for exactly one cycle, aligned with the new `lfsr_out`.
- Reset asserted mid-sequence returns all registers to their reset values immediately, without waiting for a clock edge.
- With `en` held high and a maximal tap mask, `wrap` recurs every 2^NUM_BITS-1 cycles. `step_count` runs 1..2^NUM_BITS-2, then returns to 0.

## Structure
- Shared package `lfsr_pkg` holds:
  - the FSM state enum (`LFSR_IDLE`, `LFSR_RUN`);
  - the topology constants (`LFSR_FIB`=0, `LFSR_GAL`=1);
  - recommended maximal tap masks per width for the Fibonacci and Galois forms (e.g. 5-bit Galois 5'b10100).
- Sub-module `lfsr_next`: purely combinational next-state function, parametrised by `NUM_BITS`, `TAPS` and `GALOIS`. `lfsr_gen` instantiates it once.

## Test plan
- Reset, then `en` high with defaults: `lfsr_out` runs 1, 16, 8, 4, 18, 9, 20; `out_valid` rises on the first step.
- Defaults, `en` held high for 31 cycles: `wrap` pulses on step 31 with `lfsr_out`=1; `step_count` runs up to 30, then 0; no repeated state before the wrap.
- `GALOIS`=1, `TAPS`=5'b10100, seed 1: `lfsr_out` runs 20, 10, 5, 22, 11, 17; `wrap` occurs after 31 steps.
- `load` with `seed`=0: `lfsr_out`=`SEED_DEFAULT` and `seed_err` pulses for 1 cycle. `load` with seed 7 and `en` together: `lfsr_out`=7, `step_count`=0, no step taken.
- Load 9, step 3 times, hold `en` low for 5 cycles: outputs stay frozen and `step_count`=3. Resume: `wrap` fires when the state returns to 9.
- Assert `rst` mid-sequence between clock edges: outputs return to their reset values immediately; FSM is back in IDLE and `out_valid`=0.
